// File: rtl/mem_responder_l3.sv
// mem_responder_l3: server end of a val/rdy memory interface.
// Word store with a fixed accept-to-response latency, an in-order output
// FIFO and a credit counter that bounds requests in flight.
// Message layout (MSB..LSB): {op[1:0], opaque, addr[31:0], strb[3:0], data[31:0]}.
// op: 0 = READ, 1 = WRITE; any other code is served as a READ.
// Optional macro MEM_RESPONDER_STALL_EN: an LFSR randomly withholds req_rdy.
module mem_responder_l3 #(
  parameter int          p_mem_words     = 1024,
  parameter logic [31:0] p_base_addr     = 32'h200,
  parameter int          p_latency       = 2,
  parameter int          p_max_in_flight = 8,
  parameter int          p_opaque_bits   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mem_req_val,
  output logic                     mem_req_rdy,
  input  logic [p_opaque_bits+69:0] mem_req_msg,
  output logic                     mem_resp_val,
  input  logic                     mem_resp_rdy,
  output logic [p_opaque_bits+69:0] mem_resp_msg
);

  localparam int MSG_W = p_opaque_bits + 70;
  localparam int IW    = $clog2(p_mem_words);
  localparam int CW    = $clog2(p_max_in_flight + 1);
  localparam int PW    = (p_max_in_flight > 1) ? $clog2(p_max_in_flight) : 1;
  localparam int PN    = (p_latency > 1) ? p_latency - 1 : 1;
  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;

  // Request field decode
  logic [1:0]               req_op;
  logic [p_opaque_bits-1:0] req_opq;
  logic [31:0]              req_addr, req_data, off;
  logic [3:0]               req_strb;
  logic [IW-1:0]            idx;
  logic                     unused_off;

  assign req_op   = mem_req_msg[MSG_W-1 -: 2];
  assign req_opq  = mem_req_msg[68 +: p_opaque_bits];
  assign req_addr = mem_req_msg[36 +: 32];
  assign req_strb = mem_req_msg[32 +: 4];
  assign req_data = mem_req_msg[31:0];
  // Word index wraps modulo the store size; byte offset bits are ignored.
  assign off        = req_addr - p_base_addr;
  assign idx        = off[IW+1:2];
  assign unused_off = ^{off[31:IW+2], off[1:0]};

  logic             stall;
  logic             accept, pop, push, is_wr;
  logic [CW-1:0]    count_q, count_d;
  logic [31:0]      mem_q [p_mem_words];
  logic [MSG_W-1:0] acc_msg;

  assign mem_req_rdy = (count_q < CW'(p_max_in_flight)) && !stall;
  assign accept      = mem_req_val && mem_req_rdy;
  assign pop         = mem_resp_val && mem_resp_rdy;
  assign is_wr       = (req_op == OP_WRITE);
  // Read data is captured at accept, before this edge's write lands.
  assign acc_msg     = {req_op, req_opq, req_addr, req_strb, is_wr ? 32'h0 : mem_q[idx]};

`ifdef MEM_RESPONDER_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR, taps 16/14/13/11
  always_comb lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  // LFSR state register
  always_ff @(posedge clk or posedge rst)
    if (rst) lfsr_q <= 16'hACE1;
    else     lfsr_q <= lfsr_d;

  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

`ifndef SYNTHESIS
  // Sim-only backdoor preload; the write lands on the next clock edge.
  logic          bd_pend = 1'b0;
  logic [IW-1:0] bd_idx;
  logic [31:0]   bd_data;

  task automatic init_word(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] o;
    o       = addr - p_base_addr;
    bd_idx  = o[IW+1:2];
    bd_data = data;
    bd_pend = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bd_pend = 1'b0;
  endtask

  function automatic string trace();
    string s;
    s = (accept) ? $sformatf("%h>%0d", req_addr, req_op) : "           ";
    s = {s, " | "};
    if (pop) s = {s, $sformatf("%h", mem_resp_msg[31:0])};
    return s;
  endfunction

  // Unknown opcodes are served as reads but flagged in simulation
  always_ff @(posedge clk)
    if (!rst && accept) assert (req_op == OP_READ || req_op == OP_WRITE);
`endif

  // Word store: byte-strobed writes on accept; not reset
  always_ff @(posedge clk) begin
    if (accept && is_wr)
      for (int b = 0; b < 4; b++)
        if (req_strb[b]) mem_q[idx][8*b +: 8] <= req_data[8*b +: 8];
`ifndef SYNTHESIS
    if (bd_pend) mem_q[bd_idx] <= bd_data;
`endif
  end

  // Latency pipeline: stage 0 loads the accepted response
  logic [PN-1:0]    pipe_vld_q, pipe_vld_d;
  logic [MSG_W-1:0] pipe_msg_q [PN];
  logic [MSG_W-1:0] pipe_msg_d [PN];
  logic             in_vld;
  logic [MSG_W-1:0] in_msg;

  // Next pipeline contents: shift by one stage each cycle
  always_comb begin
    pipe_vld_d[0] = accept;
    pipe_msg_d[0] = acc_msg;
    for (int i = 1; i < PN; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_msg_d[i] = pipe_msg_q[i-1];
    end
  end

  // Pipeline valid bits (reset) and payload (no reset)
  always_ff @(posedge clk or posedge rst)
    if (rst) pipe_vld_q <= '0;
    else     pipe_vld_q <= pipe_vld_d;

  // Pipeline payload registers
  always_ff @(posedge clk)
    for (int i = 0; i < PN; i++) pipe_msg_q[i] <= pipe_msg_d[i];

  // The FIFO write itself is the last stage of latency
  if (p_latency > 1) begin : g_pipe
    assign in_vld = pipe_vld_q[PN-1];
    assign in_msg = pipe_msg_q[PN-1];
  end else begin : g_nopipe
    assign in_vld = accept;
    assign in_msg = acc_msg;
  end

  // Ordered output FIFO; credits guarantee it never overflows
  logic [MSG_W-1:0] fifo_mem_q [p_max_in_flight];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    fifo_cnt_q, fifo_cnt_d;

  assign push         = in_vld;
  assign mem_resp_val = (fifo_cnt_q != '0);
  assign mem_resp_msg = fifo_mem_q[rd_ptr_q];

  // Next-state for credit counter and FIFO pointers
  always_comb begin
    count_d    = count_q;
    fifo_cnt_d = fifo_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (accept && !pop)      count_d = count_q + 1'b1;
    else if (!accept && pop) count_d = count_q - 1'b1;
    if (push && !pop)        fifo_cnt_d = fifo_cnt_q + 1'b1;
    else if (!push && pop)   fifo_cnt_d = fifo_cnt_q - 1'b1;
    if (push) wr_ptr_d = (wr_ptr_q == PW'(p_max_in_flight - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == PW'(p_max_in_flight - 1)) ? '0 : rd_ptr_q + 1'b1;
  end

  // Control state; reset drops everything in flight
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      count_q    <= '0;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      count_q    <= count_d;
      fifo_cnt_q <= fifo_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end

  // FIFO storage write
  always_ff @(posedge clk)
    if (push) fifo_mem_q[wr_ptr_q] <= in_msg;

endmodule

// File: tb/tb_mem_responder_l3.sv
// Directed bench for mem_responder_l3 with a queue/array reference model.
module tb_mem_responder_l3;
  localparam int MW = 78;
  localparam logic [1:0] RD = 2'd0, WR = 2'd1;

  logic          clk = 1'b0, rst;
  logic          req_val, req_rdy, resp_val, resp_rdy;
  logic [MW-1:0] req_msg, resp_msg;

  mem_responder_l3 dut (
    .clk(clk), .rst(rst),
    .mem_req_val(req_val), .mem_req_rdy(req_rdy), .mem_req_msg(req_msg),
    .mem_resp_val(resp_val), .mem_resp_rdy(resp_rdy), .mem_resp_msg(resp_msg)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0, checks = 0;
  logic [31:0] gold [1024];
  typedef struct { int t; logic [MW-1:0] msg; } exp_t;
  exp_t          expq[$];
  logic [MW-1:0] gotq[$];
  int            resp_times[$];
  bit            rand_rdy = 0;

  function automatic logic [MW-1:0] pack(logic [1:0] op, logic [7:0] opq, logic [31:0] a,
                                         logic [3:0] s, logic [31:0] d);
    return {op, opq, a, s, d};
  endfunction

  function automatic int widx(logic [31:0] a);
    logic [31:0] o;
    o = a - 32'h200;
    return int'(o[11:2]);
  endfunction

  task automatic check(string name, logic [127:0] got, logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference model and per-cycle compare; samples mid-cycle at negedge
  always @(negedge clk) begin : mon
    bit ev;
    logic [1:0] op;
    logic [31:0] a, d, rdata;
    logic [3:0] s;
    int i;
    exp_t e;
    if (rst) expq.delete();
    else begin
      // Front response is due p_latency(=2) cycles after its accept.
      ev = (expq.size() > 0) && (expq[0].t + 2 <= cyc);
      check("resp_val", resp_val, ev);
`ifndef MEM_RESPONDER_STALL_EN
      check("req_rdy", req_rdy, expq.size() < 8);
`else
      check("req_rdy_credit", req_rdy && (expq.size() >= 8), 1'b0);
`endif
      if (resp_val && ev) check("resp_msg", resp_msg, expq[0].msg);
      if (resp_val && resp_rdy) begin
        gotq.push_back(resp_msg);
        resp_times.push_back(cyc);
        if (expq.size() > 0) void'(expq.pop_front());
      end
      if (req_val && req_rdy) begin
        op = req_msg[77:76];
        a  = req_msg[67:36];
        s  = req_msg[35:32];
        d  = req_msg[31:0];
        i  = widx(a);
        rdata = gold[i];
        if (op == WR) begin
          for (int b = 0; b < 4; b++) if (s[b]) gold[i][8*b +: 8] = d[8*b +: 8];
          rdata = 32'h0;
        end
        e.t   = cyc;
        e.msg = {op, req_msg[75:68], a, s, rdata};
        expq.push_back(e);
      end
    end
  end

  // Random response backpressure when enabled
  initial forever begin
    @(posedge clk);
    #1;
    if (rand_rdy) resp_rdy = 1'($urandom_range(0, 1));
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic init(logic [31:0] a, logic [31:0] d);
    dut.init_word(a, d);
    gold[widx(a)] = d;
    @(posedge clk);
    #1;
  endtask

  // Present a request until accepted; returns at posedge+1 after the accept edge
  task automatic send(logic [1:0] op, logic [31:0] a, logic [3:0] s, logic [31:0] d, logic [7:0] opq);
    int n;
    n = 0;
    req_val = 1'b1;
    req_msg = pack(op, opq, a, s, d);
    forever begin
      @(negedge clk);
      if (req_rdy) break;
      n++;
      if (n > 500) begin
        check("send_timeout", n, 0);
        break;
      end
    end
    @(posedge clk);
    #1;
    req_val = 1'b0;
  endtask

  task automatic wait_resp(int n, string name);
    int k;
    k = 0;
    while (gotq.size() < n && k < 300) begin
      @(negedge clk);
      k++;
    end
    check(name, gotq.size(), n);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int t0, t1, acc;
    rst = 1'b1; req_val = 1'b0; req_msg = '0; resp_rdy = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_resp_val", resp_val, 1'b0);
    check("rst_req_rdy", req_rdy, 1'b1);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single read, latency 2
    init(32'h200, 32'h13);
    send(RD, 32'h200, 4'h0, 32'h0, 8'h5A);
    @(negedge clk);
    check("lat_t1", resp_val, 1'b0);
    @(negedge clk);
    check("lat_t2", resp_val, 1'b1);
    check("t1_data", resp_msg[31:0], 32'h13);
    check("t1_addr", resp_msg[67:36], 32'h200);
    check("t1_opaque", resp_msg[75:68], 8'h5A);
    @(posedge clk);
    #1;

    // 16 back-to-back reads
    for (int i = 0; i < 16; i++) init(32'h200 + 4 * i, 32'h1000 + i);
    gotq.delete(); resp_times.delete();
    t0 = cyc;
    for (int i = 0; i < 16; i++) send(RD, 32'h200 + 4 * i, 4'h0, 32'h0, 8'(i));
    t1 = cyc;
    wait_resp(16, "b2b_count");
`ifndef MEM_RESPONDER_STALL_EN
    check("b2b_accept_cycles", t1 - t0, 16);
    check("b2b_no_bubbles", resp_times[15] - resp_times[0], 15);
`endif
    for (int i = 0; i < 16; i++) check("b2b_data", gotq[i][31:0], 32'h1000 + i);

    // Credit limit with resp_rdy held low
    resp_rdy = 1'b0;
    acc = 0;
    req_val = 1'b1;
    req_msg = pack(RD, 8'h0, 32'h200, 4'h0, 32'h0);
    repeat (40) begin
      @(negedge clk);
      if (req_rdy) acc++;
      @(posedge clk);
      #1 req_msg = pack(RD, 8'(acc), 32'h200 + 4 * acc, 4'h0, 32'h0);
    end
    req_val = 1'b0;
    check("credit_accepts", acc, 8);
    @(negedge clk);
    check("credit_rdy_low", req_rdy, 1'b0);
    @(posedge clk);
    #1 gotq.delete();
    resp_rdy = 1'b1;
    wait_resp(8, "credit_drain");
    for (int i = 0; i < 8; i++) check("credit_order", gotq[i][75:68], 8'(i));
`ifndef MEM_RESPONDER_STALL_EN
    @(negedge clk);
    check("credit_rdy_back", req_rdy, 1'b1);
    @(posedge clk);
    #1;
`endif

    // Strobed write, then read-back; index wrap both directions
    init(32'h204, 32'h11111111);
    gotq.delete();
    send(WR, 32'h204, 4'b0101, 32'hAABBCCDD, 8'h77);
    send(RD, 32'h204, 4'h0, 32'h0, 8'h78);
    send(WR, 32'h1200, 4'hF, 32'hCAFEF00D, 8'h79);
    send(RD, 32'h200, 4'h0, 32'h0, 8'h7A);
    send(WR, 32'h1FE, 4'hF, 32'h12345678, 8'h7B);
    send(RD, 32'h11FC, 4'h0, 32'h0, 8'h7C);
    wait_resp(6, "wr_count");
    check("wr_resp_data", gotq[0][31:0], 32'h0);
    check("strb_merge", gotq[1][31:0], 32'h11BB11DD);
    check("wrap_high", gotq[3][31:0], 32'hCAFEF00D);
    check("wrap_low", gotq[5][31:0], 32'h12345678);

    // Asynchronous reset mid-cycle with 5 in flight
    resp_rdy = 1'b0;
    for (int i = 0; i < 5; i++) send(RD, 32'h210 + 4 * i, 4'h0, 32'h0, 8'(i));
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_resp_val", resp_val, 1'b0);
    check("async_rst_req_rdy", req_rdy, 1'b1);
    @(posedge clk);
    #1 rst = 1'b0;
    resp_rdy = 1'b1;
    gotq.delete();
    send(RD, 32'h204, 4'h0, 32'h0, 8'h55);
    wait_resp(1, "post_rst_count");
    check("post_rst_data", gotq[0][31:0], 32'h11BB11DD);
    repeat (4) @(posedge clk);
    #1 check("post_rst_no_stale", gotq.size(), 1);

    // Random mix with random backpressure
    rand_rdy = 1;
    for (int i = 0; i < 100; i++)
      send(($urandom_range(0, 1) != 0) ? WR : RD,
           32'h200 + 4 * $urandom_range(0, 15) + $urandom_range(0, 3),
           4'($urandom_range(0, 15)), $urandom, 8'(i));
    rand_rdy = 0;
    @(posedge clk);
    #2 resp_rdy = 1'b1;
    for (int k = 0; k < 300 && expq.size() > 0; k++) @(negedge clk);
    check("rand_drain", expq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
